// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, ALU functions,
// register ids, status encodings and the branch-condition helper.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] ALUADD = 2'd0;
  localparam logic [1:0] ALUSUB = 2'd1;
  localparam logic [1:0] ALUAND = 2'd2;
  localparam logic [1:0] ALUXOR = 2'd3;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_e;

  function automatic logic cond_eval(
    input logic [3:0] fn,
    input logic       zf,
    input logic       sf,
    input logic       of
  );
    logic lt;
    lt = sf ^ of;
    case (fn)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = lt | zf;
      4'h2:    cond_eval = lt;
      4'h3:    cond_eval = zf;
      4'h4:    cond_eval = !zf;
      4'h5:    cond_eval = !lt;
      4'h6:    cond_eval = !lt && !zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU: y = b op a, with zero/sign/overflow flags.
module y86_alu
  import y86_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [1:0]  fn,
  output logic [63:0] y,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  always_comb begin
    y  = b + a;
    of = 1'b0;
    unique case (fn)
      ALUADD: begin
        y  = b + a;
        of = (a[63] == b[63]) && (y[63] != b[63]);
      end
      ALUSUB: begin
        y  = b - a;
        of = (a[63] != b[63]) && (y[63] != b[63]);
      end
      ALUAND: y = b & a;
      ALUXOR: y = b ^ a;
    endcase
  end

  assign zf = (y == 64'd0);
  assign sf = y[63];

endmodule

// File: rtl/y86_dec_exe_mem.sv
// Y86-64 decode/execute/memory/write-back datapath with sticky halt.
// Data memory starts cleared.
module y86_dec_exe_mem
  import y86_pkg::*;
#(
  parameter int    MEM_BYTES = 8192,
  parameter string DMEM_FILE = "data_mem.hex"
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] valE,
  output logic [63:0] valM,
  output logic        Cnd,
  output logic [1:0]  stat
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [63:0] regs [15];
  logic [7:0]  mem  [MEM_BYTES] = '{default: 8'h00};

  logic        zf, sf, of, halted;
  logic        a_zf, a_sf, a_of;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] alu_a, alu_b, mem_addr, mem_wdata;
  logic [1:0]  alu_fn;
  logic        mem_rd, mem_wr, dmem_error, wr_ok;
  logic [AW-1:0] base;
  stat_e       st;

  assign Cnd = cond_eval(ifun, zf, sf, of);

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (icode)
      IRRMOVQ: begin
        src_a = rA;
        if (Cnd) dst_e = rB;
      end
      IIRMOVQ: dst_e = rB;
      IRMMOVQ: begin
        src_a = rA;
        src_b = rB;
      end
      IMRMOVQ: begin
        src_b = rB;
        dst_m = rA;
      end
      IOPQ: begin
        src_a = rA;
        src_b = rB;
        dst_e = rB;
      end
      ICALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      IRET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPUSHQ: begin
        src_a = rA;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPOPQ: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = rA;
      end
      default: ;
    endcase
  end

  assign valA = (src_a == RNONE) ? 64'd0 : regs[src_a];
  assign valB = (src_b == RNONE) ? 64'd0 : regs[src_b];

  always_comb begin
    alu_a = 64'd0;
    alu_b = 64'd0;
    unique case (icode)
      IRRMOVQ:                  alu_a = valA;
      IOPQ:    begin alu_a = valA; alu_b = valB; end
      IIRMOVQ:                  alu_a = valC;
      IRMMOVQ, IMRMOVQ: begin alu_a = valC; alu_b = valB; end
      ICALL, IPUSHQ: begin alu_a = -64'd8; alu_b = valB; end
      IRET, IPOPQ:   begin alu_a = 64'd8;  alu_b = valB; end
      default: ;
    endcase
  end

  assign alu_fn = (icode == IOPQ) ? ifun[1:0] : ALUADD;

  y86_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .fn (alu_fn),
    .y  (valE),
    .zf (a_zf),
    .sf (a_sf),
    .of (a_of)
  );

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = valE;
    mem_wdata = valA;
    unique case (icode)
      IRMMOVQ, IPUSHQ: mem_wr = 1'b1;
      IMRMOVQ:         mem_rd = 1'b1;
      ICALL: begin
        mem_wr    = 1'b1;
        mem_wdata = valP;
      end
      IRET, IPOPQ: begin
        mem_rd   = 1'b1;
        mem_addr = valA;
      end
      default: ;
    endcase
  end

  assign dmem_error = (mem_rd || mem_wr) &&
                      (mem_addr > 64'(MEM_BYTES - 8));
  assign base = mem_addr[AW-1:0];

  always_comb begin
    valM = 64'd0;
    if (mem_rd && !dmem_error)
      for (int i = 0; i < 8; i++)
        valM[8*i +: 8] = mem[base + AW'(i)];
  end

  always_comb begin
    if (imem_error || dmem_error) st = S_ADR;
    else if (!instr_valid)        st = S_INS;
    else if (icode == IHALT)      st = S_HLT;
    else                          st = S_AOK;
  end

  assign stat  = st;
  assign wr_ok = (st == S_AOK) && !halted;

  always_ff @(posedge clock) begin
    if (wr_ok && mem_wr)
      for (int i = 0; i < 8; i++)
        mem[base + AW'(i)] <= mem_wdata[8*i +: 8];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
    end else if (wr_ok) begin
      if (dst_e != RNONE) regs[dst_e] <= valE;
      if (dst_m != RNONE) regs[dst_m] <= valM;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      zf     <= 1'b1;
      sf     <= 1'b0;
      of     <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (st != S_AOK) halted <= 1'b1;
      if (wr_ok && icode == IOPQ) begin
        zf <= a_zf;
        sf <= a_sf;
        of <= a_of;
      end
    end
  end

endmodule

// File: tb/tb_y86_dec_exe_mem.sv
// Directed-vector bench for y86_dec_exe_mem.
// Drives on the falling edge, checks combinational outputs 1 ns later.
module tb_y86_dec_exe_mem;

  localparam int MB = 8192;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_valid, imem_error;
  logic [63:0] valA, valB, valE, valM;
  logic        Cnd;
  logic [1:0]  stat;

  int total = 0;
  int bad   = 0;

  y86_dec_exe_mem #(.MEM_BYTES(MB)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .valP        (valP),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .valA        (valA),
    .valB        (valB),
    .valE        (valE),
    .valM        (valM),
    .Cnd         (Cnd),
    .stat        (stat)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc);
    icode = ic;
    ifun = fn;
    rA = ra;
    rB = rb;
    valC = vc;
    valP = 64'h400;
    instr_valid = 1'b1;
    imem_error = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic irmov(input logic [3:0] rb, input logic [63:0] v);
    drive(4'h3, 4'h0, 4'hF, rb, v);
    tick();
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] r,
                         input logic [63:0] exp);
    drive(4'h2, 4'h0, r, 4'hF, 64'd0);
    chk(tag, valA, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;

    drive(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    chk("rst_stat", 64'(stat), 64'd0);
    chk_reg("rst_rax", 4'h0, 64'd0);
    drive(4'h7, 4'h3, 4'hF, 4'hF, 64'd0);
    chk("rst_zf_je", 64'(Cnd), 64'd1);

    drive(4'h3, 4'h0, 4'hF, 4'h0, 64'd10);
    chk("irm_valE", valE, 64'd10);
    tick();
    chk_reg("irm_rax", 4'h0, 64'd10);

    irmov(4'h0, 64'd3);
    irmov(4'h3, 64'd3);
    drive(4'h6, 4'h1, 4'h0, 4'h3, 64'd0);
    chk("sub_valE", valE, 64'd0);
    tick();
    drive(4'h7, 4'h3, 4'hF, 4'hF, 64'd0);
    chk("sub_je", 64'(Cnd), 64'd1);
    drive(4'h7, 4'h4, 4'hF, 4'hF, 64'd0);
    chk("sub_jne", 64'(Cnd), 64'd0);

    irmov(4'h0, 64'd1);
    irmov(4'h3, 64'h7FFF_FFFF_FFFF_FFFF);
    drive(4'h6, 4'h0, 4'h0, 4'h3, 64'd0);
    chk("ovf_valE", valE, 64'h8000_0000_0000_0000);
    tick();
    chk_reg("ovf_rbx", 4'h3, 64'h8000_0000_0000_0000);
    drive(4'h7, 4'h2, 4'hF, 4'hF, 64'd0);
    chk("ovf_jl", 64'(Cnd), 64'd0);
    drive(4'h7, 4'h1, 4'hF, 4'hF, 64'd0);
    chk("ovf_jle", 64'(Cnd), 64'd0);
    drive(4'h7, 4'h5, 4'hF, 4'hF, 64'd0);
    chk("ovf_jge", 64'(Cnd), 64'd1);

    drive(4'h2, 4'h2, 4'h0, 4'h5, 64'd0);
    chk("cmovl_cnd", 64'(Cnd), 64'd0);
    tick();
    chk_reg("cmovl_r5", 4'h5, 64'd0);
    drive(4'h2, 4'h5, 4'h0, 4'h5, 64'd0);
    tick();
    chk_reg("cmovge_r5", 4'h5, 64'd1);

    irmov(4'h0, 64'h1122_3344_5566_7788);
    irmov(4'h3, 64'd100);
    drive(4'h4, 4'h0, 4'h0, 4'h3, 64'd8);
    chk("rmm_valE", valE, 64'd108);
    tick();
    drive(4'h5, 4'h0, 4'h1, 4'h3, 64'd8);
    chk("mrm_valM", valM, 64'h1122_3344_5566_7788);
    tick();
    chk_reg("mrm_rcx", 4'h1, 64'h1122_3344_5566_7788);

    irmov(4'h4, 64'd200);
    irmov(4'h0, 64'd5);
    drive(4'hA, 4'h0, 4'h0, 4'hF, 64'd0);
    chk("push_valE", valE, 64'd192);
    tick();
    chk_reg("push_rsp", 4'h4, 64'd192);
    drive(4'hB, 4'h0, 4'h2, 4'hF, 64'd0);
    chk("pop_valM", valM, 64'd5);
    chk("pop_valE", valE, 64'd200);
    tick();
    chk_reg("pop_rsp", 4'h4, 64'd200);
    chk_reg("pop_rdx", 4'h2, 64'd5);

    drive(4'hA, 4'h0, 4'h0, 4'hF, 64'd0);
    tick();
    drive(4'hB, 4'h0, 4'h4, 4'hF, 64'd0);
    tick();
    chk_reg("poprsp_wins", 4'h4, 64'd5);

    drive(4'h4, 4'h0, 4'h0, 4'hF, 64'(MB - 8));
    chk("edge_wr_stat", 64'(stat), 64'd0);
    tick();
    drive(4'h5, 4'h0, 4'h6, 4'hF, 64'(MB - 8));
    chk("edge_rd_valM", valM, 64'd5);
    tick();
    chk_reg("edge_r6", 4'h6, 64'd5);

    drive(4'h5, 4'h0, 4'h7, 4'hF, 64'(MB - 4));
    chk("adr_stat", 64'(stat), 64'd2);
    chk("adr_valM", valM, 64'd0);
    tick();
    chk_reg("adr_r7", 4'h7, 64'd0);
    irmov(4'h8, 64'd77);
    chk_reg("adr_blocked", 4'h8, 64'd0);

    chk_reg("pre_rst_rax", 4'h0, 64'd5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rax", valA, 64'd0);
    #1;
    rst_n = 1'b1;

    drive(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    instr_valid = 1'b0;
    #1;
    chk("ins_stat", 64'(stat), 64'd3);
    imem_error = 1'b1;
    #1;
    chk("imem_stat", 64'(stat), 64'd2);
    tick();

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
    chk("hlt_stat", 64'(stat), 64'd1);
    tick();
    irmov(4'h0, 64'd55);
    chk_reg("hlt_blocked", 4'h0, 64'd0);

    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    irmov(4'h0, 64'd55);
    chk_reg("post_rst_rax", 4'h0, 64'd55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
